lpif_tx_framer: RTL and testbench

LPIF_TX_FRAMER -- requirements
Module: lpif_tx_framer

---
 rtl/lpif_tx_framer.sv | 188 ++++++++++++++++++
 tb/tb_lpif_tx_framer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lpif_tx_framer.sv
// lpif_tx_framer: converts one LPIF transmit beat at a time into a serial
// stream of 8-bit symbols, wrapping TLPs in STP..END and DLLPs in SDP..END.
// Optional feature macro: LPIF_TX_EDB_EN -- when defined, a TLP-end byte with
// lp_tlpedb set closes with EDB (0xFE) instead of END (0xFD).
module lpif_tx_framer #(
    parameter int lpif_bus_width = 32
) (
    input  logic                        lclk,
    input  logic                        reset,
    input  logic                        lp_irdy,
    input  logic [lpif_bus_width-1:0]   lp_data,
    input  logic [lpif_bus_width/8-1:0] lp_valid,
    input  logic [lpif_bus_width/8-1:0] lp_tlp_start,
    input  logic [lpif_bus_width/8-1:0] lp_tlp_end,
    input  logic [lpif_bus_width/8-1:0] lp_dllp_start,
    input  logic [lpif_bus_width/8-1:0] lp_dllp_end,
    input  logic [lpif_bus_width/8-1:0] lp_tlpedb,
    output logic                        pl_trdy,
    output logic [7:0]                  tx_data,
    output logic                        tx_datak,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        frame_open,
    output logic                        frm_err
);
    localparam int NB = lpif_bus_width / 8;
    localparam int LW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
`ifdef LPIF_TX_EDB_EN
    localparam logic [7:0] SYM_EDB = 8'hFE;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, END} state_t;

    state_t                    state_q, state_d;
    logic [LW-1:0]             lane_q, lane_d;
    logic [lpif_bus_width-1:0] buf_data_q, v_data;
    logic [NB-1:0]             buf_valid_q, v_valid;
    logic [NB-1:0]             buf_ts_q, v_ts;
    logic [NB-1:0]             buf_te_q, v_te;
    logic [NB-1:0]             buf_ds_q, v_ds;
    logic [NB-1:0]             buf_de_q, v_de;
`ifdef LPIF_TX_EDB_EN
    logic [NB-1:0]             buf_edb_q, v_edb;
`else
    logic                      unused_edb;
    assign unused_edb = ^lp_tlpedb;
`endif
    logic [7:0]                tx_data_q, tx_data_d;
    logic                      tx_datak_q, tx_datak_d;
    logic                      tx_valid_q, tx_valid_d;
    logic                      frame_open_q, frame_open_d;
    logic                      frm_err_q, frm_err_d;
    logic                      accept, consume;
    logic [LW:0]               nxt;

    // Lowest valid lane at or above 'from'; MSB of the result flags "found".
    function automatic logic [LW:0] find_valid(input logic [NB-1:0] vld, input int from);
        logic [LW:0] res;
        res = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (vld[i] && i >= from) res = {1'b1, LW'(i)};
        end
        return res;
    endfunction

    // Next-state, buffer load and next-symbol decode; buffer view is the
    // incoming beat on acceptance so the first symbol is ready one cycle later.
    always_comb begin
        accept  = lp_irdy && (state_q == IDLE);
        consume = tx_valid_q && tx_ready;
        v_data  = accept ? lp_data       : buf_data_q;
        v_valid = accept ? lp_valid      : buf_valid_q;
        v_ts    = accept ? lp_tlp_start  : buf_ts_q;
        v_te    = accept ? lp_tlp_end    : buf_te_q;
        v_ds    = accept ? lp_dllp_start : buf_ds_q;
        v_de    = accept ? lp_dllp_end   : buf_de_q;
`ifdef LPIF_TX_EDB_EN
        v_edb   = accept ? lp_tlpedb     : buf_edb_q;
`endif
        state_d      = state_q;
        lane_d       = lane_q;
        frame_open_d = frame_open_q;
        frm_err_d    = 1'b0;
        nxt          = '0;

        if (accept) begin
            nxt = find_valid(v_valid, 0);
        end else if (consume) begin
            case (state_q)
                START: begin
                    frm_err_d    = frame_open_q;
                    frame_open_d = 1'b1;
                    state_d      = DATA;
                end
                DATA: begin
                    if (v_te[lane_q] || v_de[lane_q]) begin
                        state_d = END;
                    end else begin
                        nxt     = find_valid(v_valid, int'(lane_q) + 1);
                        state_d = IDLE;
                    end
                end
                END: begin
                    frm_err_d    = !frame_open_q;
                    frame_open_d = 1'b0;
                    nxt          = find_valid(v_valid, int'(lane_q) + 1);
                    state_d      = IDLE;
                end
                default: ;
            endcase
        end

        // Entering a new byte: start symbol first if the lane carries one.
        if (nxt[LW]) begin
            lane_d  = nxt[LW-1:0];
            state_d = (v_ts[lane_d] || v_ds[lane_d]) ? START : DATA;
        end

        tx_data_d  = 8'h00;
        tx_datak_d = 1'b0;
        case (state_d)
            START: begin
                tx_datak_d = 1'b1;
                tx_data_d  = v_ts[lane_d] ? SYM_STP : SYM_SDP;
            end
            DATA: tx_data_d = v_data[int'(lane_d) * 8 +: 8];
            END: begin
                tx_datak_d = 1'b1;
                tx_data_d  = SYM_END;
`ifdef LPIF_TX_EDB_EN
                if (v_edb[lane_d] && v_te[lane_d]) tx_data_d = SYM_EDB;
`endif
            end
            default: ;
        endcase
        tx_valid_d = (state_d != IDLE);
    end

    // FSM, beat buffer and registered outputs; reset wins over acceptance.
    always_ff @(posedge lclk) begin
        if (reset) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            buf_data_q   <= '0;
            buf_valid_q  <= '0;
            buf_ts_q     <= '0;
            buf_te_q     <= '0;
            buf_ds_q     <= '0;
            buf_de_q     <= '0;
`ifdef LPIF_TX_EDB_EN
            buf_edb_q    <= '0;
`endif
            tx_data_q    <= 8'h00;
            tx_datak_q   <= 1'b0;
            tx_valid_q   <= 1'b0;
            frame_open_q <= 1'b0;
            frm_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            buf_data_q   <= v_data;
            buf_valid_q  <= v_valid;
            buf_ts_q     <= v_ts;
            buf_te_q     <= v_te;
            buf_ds_q     <= v_ds;
            buf_de_q     <= v_de;
`ifdef LPIF_TX_EDB_EN
            buf_edb_q    <= v_edb;
`endif
            tx_data_q    <= tx_data_d;
            tx_datak_q   <= tx_datak_d;
            tx_valid_q   <= tx_valid_d;
            frame_open_q <= frame_open_d;
            frm_err_q    <= frm_err_d;
        end
    end

    assign pl_trdy    = (state_q == IDLE);
    assign tx_data    = tx_data_q;
    assign tx_datak   = tx_datak_q;
    assign tx_valid   = tx_valid_q;
    assign frame_open = frame_open_q;
    assign frm_err    = frm_err_q;
endmodule

// File: tb/tb_lpif_tx_framer.sv
// Bench for lpif_tx_framer (width 32): a symbol-queue model built from the
// framing rules, a per-cycle compare process, and directed literal checks.
module tb_lpif_tx_framer;
    logic        lclk = 0, reset = 1, lp_irdy = 0, tx_ready = 1;
    logic [31:0] lp_data = '0;
    logic [3:0]  lp_valid = '0, lp_tlp_start = '0, lp_tlp_end = '0;
    logic [3:0]  lp_dllp_start = '0, lp_dllp_end = '0, lp_tlpedb = '0;
    logic        pl_trdy, tx_datak, tx_valid, frame_open, frm_err;
    logic [7:0]  tx_data;

`ifdef LPIF_TX_EDB_EN
    localparam bit EDB = 1'b1;
`else
    localparam bit EDB = 1'b0;
`endif

    lpif_tx_framer #(.lpif_bus_width(32)) dut (
        .lclk(lclk), .reset(reset), .lp_irdy(lp_irdy), .lp_data(lp_data),
        .lp_valid(lp_valid), .lp_tlp_start(lp_tlp_start), .lp_tlp_end(lp_tlp_end),
        .lp_dllp_start(lp_dllp_start), .lp_dllp_end(lp_dllp_end), .lp_tlpedb(lp_tlpedb),
        .pl_trdy(pl_trdy), .tx_data(tx_data), .tx_datak(tx_datak), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .frame_open(frame_open), .frm_err(frm_err));

    always #5 lclk = ~lclk;

    int tests = 0, fails = 0, err_cnt = 0;
    logic [8:0] q[$];    // expected symbols {k, byte}
    logic [8:0] log[$];  // consumed symbols
    logic exp_open = 0, exp_err = 0, hold_pend = 0;
    logic [8:0] held;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected symbols of one beat, straight from the framing rules.
    task automatic model_beat(input logic [31:0] d, input logic [3:0] v, ts, te, ds, de, edb);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                if (ts[i]) q.push_back(9'h1FB);
                else if (ds[i]) q.push_back(9'h15C);
                q.push_back({1'b0, d[8*i +: 8]});
                if (te[i] || de[i]) q.push_back((EDB && edb[i] && te[i]) ? 9'h1FE : 9'h1FD);
            end
        end
    endtask

    // Compare process: symbol order, hold under back-pressure, idle zeros, frame status.
    always @(negedge lclk) begin
        logic [8:0] s;
        s = {tx_datak, tx_data};
        chk("frm_err", {31'b0, frm_err}, {31'b0, exp_err});
        chk("frame_open", {31'b0, frame_open}, {31'b0, exp_open});
        if (frm_err) err_cnt++;
        if (!tx_valid) chk("idle_symbol", {23'b0, s}, 32'h0);
        if (hold_pend && tx_valid) chk("hold_stable", {23'b0, s}, {23'b0, held});
        exp_err = 1'b0;
        hold_pend = 1'b0;
        if (reset) begin
            q.delete();
            exp_open = 1'b0;
        end else if (tx_valid && tx_ready) begin
            log.push_back(s);
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL spurious_symbol: got %0h expected none", s);
            end else begin
                chk("symbol", {23'b0, s}, {23'b0, q.pop_front()});
                if (s == 9'h1FB || s == 9'h15C) begin exp_err = exp_open; exp_open = 1'b1; end
                if (s == 9'h1FD || s == 9'h1FE) begin exp_err = !exp_open; exp_open = 1'b0; end
            end
        end else if (tx_valid) begin
            hold_pend = 1'b1;
            held = s;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] v, ts, te, ds, de, edb);
        int n;
        @(posedge lclk); #1;
        lp_data = d; lp_valid = v; lp_tlp_start = ts; lp_tlp_end = te;
        lp_dllp_start = ds; lp_dllp_end = de; lp_tlpedb = edb; lp_irdy = 1;
        n = 0;
        forever begin
            @(negedge lclk);
            if (pl_trdy) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", {31'b0, pl_trdy}, 32'h1);
                lp_irdy = 0;
                return;
            end
        end
        model_beat(d, v, ts, te, ds, de, edb);
        @(posedge lclk); #1;
        lp_irdy = 0; lp_valid = '0; lp_tlp_start = '0; lp_tlp_end = '0;
        lp_dllp_start = '0; lp_dllp_end = '0; lp_tlpedb = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !pl_trdy || tx_valid) && n < 300) begin
            @(negedge lclk);
            n++;
        end
        chk("drain_residual", q.size(), 0);
        chk("drain_idle", {30'b0, pl_trdy, tx_valid}, 32'h2);
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [8:0] exp);
        if (idx >= log.size()) chk(nm, 32'hDEAD, {23'b0, exp});
        else chk(nm, {23'b0, log[idx]}, {23'b0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int e0;
        logic [8:0] e20[6];
        logic [8:0] e21[8];
        e20 = '{9'h1FB, 9'h011, 9'h022, 9'h033, 9'h044, 9'h1FD};
        e21 = '{9'h15C, 9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD, 9'h0EE, 9'h0FF, 9'h1FD};

        repeat (3) @(posedge lclk);
        #1 reset = 0;
        @(negedge lclk);
        chk("rst_tx_valid", {31'b0, tx_valid}, 0);
        chk("rst_tx_data", {24'b0, tx_data}, 0);
        chk("rst_tx_datak", {31'b0, tx_datak}, 0);
        chk("rst_pl_trdy", {31'b0, pl_trdy}, 1);
        chk("rst_frame_open", {31'b0, frame_open}, 0);
        chk("rst_frm_err", {31'b0, frm_err}, 0);

        // single-beat TLP
        log.delete();
        send_beat(32'h44332211, 4'hF, 4'b0001, 4'b1000, 4'b0, 4'b0, 4'b0);
        chk("lat1_valid", {31'b0, tx_valid}, 1);
        chk("lat1_symbol", {23'b0, tx_datak, tx_data}, 32'h1FB);
        cnt = 0;
        while (!pl_trdy && cnt < 50) begin cnt++; @(posedge lclk); #1; end
        chk("trdy_low_cycles", cnt, 6);
        drain();
        for (int i = 0; i < 6; i++) chk_log("tlp_seq", i, e20[i]);

        // DLLP across two beats
        log.delete();
        e0 = err_cnt;
        send_beat(32'hDDCCBBAA, 4'hF, 4'b0, 4'b0, 4'b0001, 4'b0, 4'b0);
        drain();
        chk("dllp_open_between", {31'b0, frame_open}, 1);
        send_beat(32'h0000FFEE, 4'b0011, 4'b0, 4'b0, 4'b0, 4'b0010, 4'b0);
        drain();
        for (int i = 0; i < 8; i++) chk_log("dllp_seq", i, e21[i]);
        chk("dllp_no_err", err_cnt - e0, 0);
        chk("dllp_closed", {31'b0, frame_open}, 0);

        // back-pressure mid-TLP
        log.delete();
        send_beat(32'h87654321, 4'hF, 4'b0001, 4'b1000, 4'b0, 4'b0, 4'b0);
        @(posedge lclk); @(posedge lclk); #1 tx_ready = 0;
        repeat (3) @(posedge lclk);
        #1 tx_ready = 1;
        drain();
        chk("bp_count", log.size(), 6);
        chk_log("bp_sym2", 2, 9'h043);

        // sparse lanes, start flag on an invalid lane ignored
        log.delete();
        send_beat(32'h44332211, 4'b0101, 4'b0010, 4'b0, 4'b0, 4'b0, 4'b0);
        drain();
        chk("sparse_count", log.size(), 2);
        chk_log("sparse_l0", 0, 9'h011);
        chk_log("sparse_l2", 1, 9'h033);

        // second STP while frame open
        log.delete();
        e0 = err_cnt;
        send_beat(32'h0D0C0B0A, 4'hF, 4'b0001, 4'b0, 4'b0, 4'b0, 4'b0);
        drain();
        send_beat(32'h1D1C1B1A, 4'hF, 4'b0001, 4'b1000, 4'b0, 4'b0, 4'b0);
        drain();
        chk("dup_start_err", err_cnt - e0, 1);
        chk_log("dup_stp", 5, 9'h1FB);

        // empty beat is swallowed
        log.delete();
        send_beat(32'hCAFEF00D, 4'b0, 4'b1111, 4'b1111, 4'b0, 4'b0, 4'b0);
        chk("empty_no_valid", {31'b0, tx_valid}, 0);
        chk("empty_trdy", {31'b0, pl_trdy}, 1);
        drain();
        chk("empty_count", log.size(), 0);

        // TLP end with EDB flag
        log.delete();
        send_beat(32'h55667788, 4'hF, 4'b0001, 4'b1000, 4'b0, 4'b0, 4'b1000);
        drain();
        chk_log("edb_close", 5, EDB ? 9'h1FE : 9'h1FD);

        // reset mid-beat after 2 symbols, with a beat offered during reset
        log.delete();
        send_beat(32'h55667788, 4'hF, 4'b0001, 4'b1000, 4'b0, 4'b0, 4'b1000);
        @(posedge lclk); @(posedge lclk); #1;
        reset = 1;
        lp_data = 32'h99999999; lp_valid = 4'hF; lp_tlp_start = 4'b0001; lp_irdy = 1;
        @(posedge lclk); #1;
        reset = 0; lp_irdy = 0; lp_valid = '0; lp_tlp_start = '0;
        @(negedge lclk);
        chk("mid_rst_valid", {31'b0, tx_valid}, 0);
        chk("mid_rst_trdy", {31'b0, pl_trdy}, 1);
        chk("mid_rst_open", {31'b0, frame_open}, 0);
        chk("mid_rst_count", log.size(), 2);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
